// File: rtl/scaler_axis_out.sv
// Adapts the scaler's sparse de/hs/vs pixel stream to AXI4-Stream video (tuser=SOF, tlast=EOL).
// The FIFO absorbs downstream stalls; on overflow the rest of the frame is dropped up to the next vs.
module scaler_axis_out #(
   parameter int PIXEL_WIDTH = 12,
   parameter int FIFO_AW     = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [15:0]            line_size,
   input  logic [PIXEL_WIDTH-1:0] di_i,
   input  logic                   de_i,
   input  logic                   hs_i,
   input  logic                   vs_i,
   output logic [PIXEL_WIDTH-1:0] m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tuser,
   output logic                   m_axis_tlast,
   output logic [FIFO_AW:0]       fill_level,
   output logic                   overflow,
   output logic                   line_err
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int EW    = PIXEL_WIDTH + 2;   // {sof, eol, pixel}

   typedef enum logic {WAIT_SOF, PASS} wr_state_t;

   wr_state_t            state, state_nxt;
   logic                 push, ovf_set;

   logic [EW-1:0]        mem [DEPTH];
   logic [FIFO_AW-1:0]   wr_ptr, rd_ptr;
   logic [FIFO_AW:0]     count;
   logic                 full, empty;

   logic [15:0]          pix_cnt, line_len, pix_idx, len_eff;
   logic                 prev_eol, line_start, entry_eol, long_line, short_line;

   logic [EW-1:0]        rq_data;
   logic                 rq_vld, rd_en, ld_out, out_pop;

   // count never exceeds DEPTH, so its top bit alone means full
   assign full       = count[FIFO_AW];
   assign empty      = (count == '0);
   assign fill_level = count;

   // ---------------- write side ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= WAIT_SOF;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      push      = 1'b0;
      ovf_set   = 1'b0;
      case (state)
         WAIT_SOF: begin
            if (de_i && vs_i) begin
               if (full) begin
                  ovf_set = 1'b1;
               end else begin
                  push      = 1'b1;
                  state_nxt = PASS;
               end
            end
         end
         PASS: begin
            if (de_i) begin
               if (full) begin
                  ovf_set   = 1'b1;
                  state_nxt = WAIT_SOF;
               end else begin
                  push = 1'b1;
               end
            end
         end
         default: state_nxt = WAIT_SOF;
      endcase
   end

   // A frame-start pixel is framed against the line_size it latches, not the stale one
   assign line_start = hs_i | vs_i;
   assign len_eff    = vs_i ? line_size : line_len;
   assign pix_idx    = line_start ? 16'd0 : ((&pix_cnt) ? pix_cnt : pix_cnt + 16'd1);
   assign entry_eol  = (pix_idx == len_eff);
   assign long_line  = (pix_idx > len_eff);
   assign short_line = (state == PASS) && line_start && !prev_eol;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_cnt  <= '0;
         line_len <= '0;
         prev_eol <= 1'b0;
         overflow <= 1'b0;
         line_err <= 1'b0;
      end else begin
         if (push) begin
            pix_cnt  <= pix_idx;
            prev_eol <= entry_eol;
            if (vs_i) line_len <= line_size;
            if (short_line || long_line) line_err <= 1'b1;
         end
         if (ovf_set) overflow <= 1'b1;
      end
   end

   // ---------------- FIFO storage ----------------
   always_ff @(posedge clk) begin
      if (push)  mem[wr_ptr] <= {vs_i, entry_eol, di_i};
      if (rd_en) rq_data     <= mem[rd_ptr];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)  wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({push, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- read side ----------------
   // Synchronous RAM read lands in rq_data, then moves to the output register.
   assign out_pop = m_axis_tvalid && m_axis_tready;
   assign ld_out  = rq_vld && (!m_axis_tvalid || out_pop);
   assign rd_en   = !empty && (!rq_vld || ld_out);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rq_vld        <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tuser  <= 1'b0;
         m_axis_tlast  <= 1'b0;
      end else begin
         if (rd_en)       rq_vld <= 1'b1;
         else if (ld_out) rq_vld <= 1'b0;

         if (ld_out) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tuser  <= rq_data[EW-1];
            m_axis_tlast  <= rq_data[PIXEL_WIDTH];
            m_axis_tdata  <= rq_data[PIXEL_WIDTH-1:0];
         end else if (out_pop) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_scaler_axis_out.sv
// Directed bench for scaler_axis_out: framing, latency, overflow drop, line errors, reset, random stalls.
module tb_scaler_axis_out;
   localparam int PW = 12;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   line_size = '0;
   logic [PW-1:0] di = '0;
   logic          de = 1'b0, hs = 1'b0, vs = 1'b0;
   logic [PW-1:0] tdata;
   logic          tvalid, tuser, tlast;
   logic          tready = 1'b0;
   logic [AW:0]   fill_level;
   logic          overflow, line_err;

   typedef struct packed {logic u; logic l; logic [PW-1:0] d;} beat_t;
   beat_t got[$];
   beat_t exp[$];
   beat_t prev_b;
   logic  stall = 1'b0;
   int    base = 0;
   int    nchk = 0, nerr = 0, hold_viol = 0, timeouts = 0, rdy_mode = 0, v = 0;

   always #5 clk = ~clk;

   scaler_axis_out #(.PIXEL_WIDTH(PW), .FIFO_AW(AW)) dut (
      .clk(clk), .rst(rst), .line_size(line_size),
      .di_i(di), .de_i(de), .hs_i(hs), .vs_i(vs),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .m_axis_tuser(tuser), .m_axis_tlast(tlast),
      .fill_level(fill_level), .overflow(overflow), .line_err(line_err)
   );

   // tready driver: 0 = low, 1 = high, 2 = random
   initial forever begin
      @(posedge clk); #2;
      if (rdy_mode == 2) tready = ($urandom_range(0, 1) == 1);
      else               tready = (rdy_mode == 1);
   end

   // beat collector and hold-while-stalled watcher
   always @(negedge clk) begin
      if (rst) begin
         stall <= 1'b0;
      end else begin
         if (stall && (!tvalid || {tuser, tlast, tdata} != prev_b)) hold_viol <= hold_viol + 1;
         if (tvalid && tready) got.push_back({tuser, tlast, tdata});
         stall  <= tvalid && !tready;
         prev_b <= {tuser, tlast, tdata};
      end
   end

   task automatic check(input string tag, input logic [31:0] g, input logic [31:0] e);
      nchk++;
      if (g !== e) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, g, e);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic px(input int d, input bit h, input bit s);
      di = d[PW-1:0]; de = 1'b1; hs = h; vs = s;
      tick(1);
      de = 1'b0; hs = 1'b0; vs = 1'b0;
   endtask

   task automatic expect_px(input int d, input bit u, input bit l);
      exp.push_back({u, l, d[PW-1:0]});
   endtask

   task automatic start_test();
      base = got.size();
      exp.delete();
   endtask

   task automatic compare(input string tag);
      check({tag, "_cnt"}, 32'(got.size() - base), 32'(exp.size()));
      for (int i = 0; i < exp.size() && base + i < got.size(); i++)
         check(tag, 32'(got[base + i]), 32'(exp[i]));
   endtask

   // one line at line_size = 3: tlast expected only on the 4th pixel
   task automatic send_line(input int n, input bit first, inout int val);
      for (int p = 0; p < n; p++) begin
         px(val, p == 0, first && p == 0);
         expect_px(val, first && p == 0, p == 3);
         val++;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; tick(2); rst = 1'b0; tick(1);
   endtask

   initial begin
      tick(3);
      check("rst_tvalid", 32'(tvalid), 32'd0);
      check("rst_out",    32'({tuser, tlast, tdata}), 32'd0);
      check("rst_fill",   32'(fill_level), 32'd0);
      check("rst_flags",  32'({overflow, line_err}), 32'd0);
      rst = 1'b0; rdy_mode = 1; tick(2);

      // pre-vs pixels dropped, then 2 frames of 2x4 with latency check
      start_test(); line_size = 16'd3;
      px(100, 1, 0); px(101, 0, 0); px(102, 0, 0);
      for (int f = 0; f < 2; f++)
         for (int l = 0; l < 2; l++)
            for (int p = 0; p < 4; p++) begin
               if (f == 0 && l == 0 && p == 2) check("lat_n1", 32'(tvalid), 32'd0);
               if (f == 0 && l == 0 && p == 3) check("lat_n2", 32'(tvalid), 32'd1);
               px(f * 8 + l * 4 + p, p == 0, l == 0 && p == 0);
               expect_px(f * 8 + l * 4 + p, l == 0 && p == 0, p == 3);
            end
      tick(8);
      compare("t1");
      check("t1_flags", 32'({overflow, line_err}), 32'd0);

      // short line: 4, 3, 4 pixels
      start_test(); v = 256;
      send_line(4, 1, v); check("short_le0", 32'(line_err), 32'd0);
      send_line(3, 0, v); check("short_le1", 32'(line_err), 32'd0);
      send_line(4, 0, v); check("short_le2", 32'(line_err), 32'd1);
      tick(8);
      compare("t_short");

      // long line: 4, 5, 4 pixels
      do_reset(); start_test(); v = 512;
      send_line(4, 1, v); check("long_le0", 32'(line_err), 32'd0);
      send_line(5, 0, v); check("long_le1", 32'(line_err), 32'd1);
      send_line(4, 0, v);
      tick(8);
      compare("t_long");

      // overflow: 2 held in read stage/output, 16 in RAM, rest dropped
      do_reset(); rdy_mode = 0; tick(2); start_test(); line_size = 16'd19;
      for (int i = 0; i < 20; i++) begin
         px(i, i == 0, i == 0);
         if (i < 18) expect_px(i, i == 0, 1'b0);
      end
      tick(2);
      check("ovf_fill", 32'(fill_level), 32'd16);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_head", 32'({tvalid, tuser, tlast, tdata}), 32'({1'b1, 1'b1, 1'b0, 12'h000}));
      px(99, 1, 0);
      rdy_mode = 1; tick(30);
      check("ovf_drain", 32'(fill_level), 32'd0);
      line_size = 16'd3;
      for (int i = 0; i < 4; i++) begin
         px(50 + i, i == 0, i == 0);
         expect_px(50 + i, i == 0, i == 3);
      end
      tick(8);
      compare("t_ovf");
      check("ovf_sticky", 32'({overflow, line_err}), 32'({1'b1, 1'b0}));

      // async reset with 5 pixels buffered
      rdy_mode = 0; tick(2);
      for (int i = 0; i < 5; i++) px(200 + i, i == 0, i == 0);
      tick(2);
      check("mid_fill", 32'({tvalid, fill_level}), 32'({1'b1, 5'd3}));
      rst = 1'b1; #1;
      check("mid_tvalid", 32'(tvalid), 32'd0);
      check("mid_fill0",  32'(fill_level), 32'd0);
      check("mid_flags",  32'({overflow, line_err}), 32'd0);
      tick(1); rst = 1'b0; rdy_mode = 1; tick(2);
      start_test();
      px(300, 1, 0); px(301, 0, 0);
      tick(6);
      check("mid_nosof", 32'(tvalid), 32'd0);
      compare("t_mid");

      // random tready, 3 frames of 8x64, source throttled on fill_level
      do_reset(); rdy_mode = 2; start_test(); line_size = 16'd63;
      for (int f = 0; f < 3; f++)
         for (int l = 0; l < 8; l++)
            for (int p = 0; p < 64; p++) begin
               for (int k = 0; k < 200 && fill_level >= 8; k++) tick(1);
               if (fill_level >= 8) timeouts++;
               v = (f * 512 + l * 64 + p) & 12'hFFF;
               px(v, p == 0, l == 0 && p == 0);
               expect_px(v, l == 0 && p == 0, p == 63);
            end
      for (int k = 0; k < 4000 && got.size() - base < exp.size(); k++) tick(1);
      rdy_mode = 1; tick(4);
      compare("t_rand");
      check("rand_flags", 32'({overflow, line_err}), 32'd0);
      check("rand_throttle", 32'(timeouts), 32'd0);
      check("hold_stable", 32'(hold_viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
